// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch stage and the decoder.
//   - FSM state encodings (3-bit constants, legacy-compatible)
//   - Opcode constants for the control-flow instructions
//   - instr_len(): total instruction length (1..3 bytes) derived from the opcode
package fetch_pkg;

  localparam logic [2:0] ST_OP   = 3'd0;
  localparam logic [2:0] ST_B1   = 3'd1;
  localparam logic [2:0] ST_B2   = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;

  localparam logic [7:0] OPC_HALT = 8'hFF;
  localparam logic [7:0] OPC_RET  = 8'hFB;
  localparam logic [7:0] OPC_NOP  = 8'hFC;
  localparam logic [7:0] OPC_CALL = 8'hF9;

  // Length is decided by walking the leading opcode bits:
  // 0xxx_xxxx register ops (1), 10xx_xxxx immediates (2), 110x_xxxx reserved (1),
  // 1110_xxxx conditional jumps (3), 1111_100x CALL (3), other 1111_xxxx (1).
  function automatic logic [1:0] instr_len(input logic [7:0] opcode);
    logic [1:0] len;
    if (!opcode[7])
      len = 2'd1;
    else if (!opcode[6])
      len = 2'd2;
    else if (!opcode[5])
      len = 2'd1;
    else if (!opcode[4])
      len = 2'd3;
    else if (opcode[3:1] == 3'b100)
      len = 2'd3;
    else
      len = 2'd1;
    return len;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle between the fetch stage, the byte-wide memory port,
// the redirect source (branch unit) and the decode/execute consumer.
//   mem_addr/mem_rd_data/mem_busy   memory read port (data combinational)
//   redirect/redirect_pc            PC override with flush
//   out_valid/out_ready             instruction handshake
//   out_opcode/out_op1/out_op2      assembled instruction bytes
//   out_len/out_pc                  length (1..3) and opcode address
//   halted                          HALT delivered, fetch stopped
// modport master is the fetch stage, modport slave is its environment.
interface instr_fetch_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        mem_busy;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [7:0]  out_op1;
  logic [7:0]  out_op2;
  logic [1:0]  out_len;
  logic [15:0] out_pc;
  logic        halted;

  modport master (
    output mem_addr,
    input  mem_rd_data, mem_busy,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_opcode, out_op1, out_op2, out_len, out_pc,
    output halted
  );

  modport slave (
    input  mem_addr,
    output mem_rd_data, mem_busy,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_opcode, out_op1, out_op2, out_len, out_pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetches variable-length instructions (1..3 bytes) one byte per
// cycle from a byte-wide memory and hands them to decode over valid/ready.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          instr_fetch_if.master (memory port, redirect, output handshake)
// Parameter RESET_PC is the program counter value loaded on reset.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  logic [2:0]  state;
  logic [15:0] pc;
  logic [7:0]  opcode_q;
  logic [7:0]  op1_q;
  logic [7:0]  op2_q;
  logic [1:0]  len_q;
  logic [15:0] opc_pc_q;
  logic [1:0]  cur_len;

  // The memory is always addressed by the PC; in HOLD it already points at the
  // next instruction and in HALT it simply stays frozen.
  assign bus.mem_addr   = pc;
  assign bus.out_valid  = (state == ST_HOLD);
  assign bus.halted     = (state == ST_HALT);
  assign bus.out_opcode = opcode_q;
  assign bus.out_op1    = op1_q;
  assign bus.out_op2    = op2_q;
  assign bus.out_len    = len_q;
  assign bus.out_pc     = opc_pc_q;

  assign cur_len = instr_len(bus.mem_rd_data);

  // Fetch sequencer. A redirect wins over everything except HALT; in HOLD a
  // coincident transfer needs no extra action because the consumer has
  // already taken the held bytes on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_OP;
      pc       <= RESET_PC;
      opcode_q <= 8'h00;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      len_q    <= 2'd1;
      opc_pc_q <= RESET_PC;
    end else if (bus.redirect && state != ST_HALT) begin
      state <= ST_OP;
      pc    <= bus.redirect_pc;
    end else begin
      case (state)
        ST_OP: begin
          if (!bus.mem_busy) begin
            opcode_q <= bus.mem_rd_data;
            op1_q    <= 8'h00;
            op2_q    <= 8'h00;
            len_q    <= cur_len;
            opc_pc_q <= pc;
            pc       <= pc + 16'd1;
            state    <= (cur_len == 2'd1) ? ST_HOLD : ST_B1;
          end
        end
        ST_B1: begin
          if (!bus.mem_busy) begin
            op1_q <= bus.mem_rd_data;
            pc    <= pc + 16'd1;
            state <= (len_q == 2'd2) ? ST_HOLD : ST_B2;
          end
        end
        ST_B2: begin
          if (!bus.mem_busy) begin
            op2_q <= bus.mem_rd_data;
            pc    <= pc + 16'd1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready)
            state <= (opcode_q == OPC_HALT) ? ST_HALT : ST_OP;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_OP;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the byte-wide program/data memory: drives the memory read address from a 16-bit program counter, collects the opcode and 0–2 operand bytes of each variable-length instruction, and presents the assembled instruction to the decode/execute stage over a valid/ready handshake. It also accepts PC redirects for jumps, calls and returns, and stops fetching after delivering HALT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  out  16  read address to memory; equals PC during fetch states.
- mem_rd_data  in  8  memory read data; combinational from mem_addr, same cycle.
- mem_busy  in  1  port owned by data-side access this cycle; fetch must not capture mem_rd_data.
- redirect  in  1  load new PC and flush any partial/held instruction.
- redirect_pc  in  16  target for redirect.
- out_valid  out  1  assembled instruction available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_opcode  out  8  opcode byte.
- out_op1  out  8  first operand byte (MSB of address for 3-byte), 0 if unused.
- out_op2  out  8  second operand byte (LSB of address), 0 if unused.
- out_len  out  2  instruction length in bytes, 1–3.
- out_pc  out  16  address of the opcode byte.
- halted  out  1  HALT delivered; fetch stopped.

## Operation
- Length decode on opcode: 0x00–0x7F → 1 (MOV/ALU register); 0x80–0xBF → 2 (immediate ALU, MOVI); 0xC0–0xDF → 1 (reserved); 0xE0–0xEF → 3 (conditional jumps); 0xF8–0xF9 → 3 (CALL); all other 0xF0–0xFF → 1 (RET 0xFB, NOP 0xFC, HALT 0xFF).
- States: OP, B1, B2, HOLD, HALT.
  - OP: if !mem_busy capture opcode, PC+1; len 1 → HOLD, else → B1.
  - B1: if !mem_busy capture op1, PC+1; len 2 → HOLD, else → B2.
  - B2: if !mem_busy capture op2, PC+1 → HOLD.
  - HOLD: out_valid=1; on transfer → HALT if opcode 0xFF, else OP.
  - HALT: halted=1, mem_addr held, no captures; left only by reset.
- mem_busy high in OP/B1/B2: state and PC unchanged (stall, no lost byte).
- PC arithmetic 16-bit modulo: 0xFFFF+1 = 0x0000; instructions may straddle wrap.
- Unused operand fields forced to 0 when the opcode is captured.
- redirect (any state except HALT): PC ← redirect_pc, state ← OP, partial bytes discarded, out_valid 0 next cycle. If redirect coincides with a transfer in HOLD, the transfer completes (consumer owns it) and redirect applies. redirect in HALT is ignored.
- Outputs stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release on next edge): PC=RESET_PC, state OP, out_valid=0, halted=0, out_opcode/op1/op2=0, out_len=1, out_pc=RESET_PC, mem_addr=RESET_PC.
- With mem_busy low, an N-byte instruction captured over N cycles; out_valid asserts the cycle after the last capture; minimum N+1 cycles per instruction including the transfer cycle.
- No fetch overlaps HOLD (no prefetch); mem_addr in HOLD = next PC.
- redirect effective at the edge it is sampled; mem_addr = redirect_pc the following cycle.

## Structure
- Shared package fetch_pkg: state enum, opcode constants (OPC_HALT 8'hFF, OPC_RET 8'hFB, OPC_NOP 8'hFC, OPC_CALL 8'hF9), function instr_len(opcode) used also by decode.
- Single module; no sub-module needed (length decode is the package function).

## Test plan
- Reset then memory 0x0000: BB 05 → one transfer opcode=0xBB, op1=0x05, op2=0, len=2, out_pc=0x0000, valid on cycle 2; next fetch at 0x0002.
- Bytes F9 02 00 at 0x0002 with out_ready=1 → opcode 0xF9, op1 0x02, op2 0x00, len 3; assert redirect to 0x0200 next cycle → next instruction out_pc=0x0200 (B9 01).
- out_ready held low 5 cycles on 0x52 → out_valid stays 1, all outputs constant, PC frozen; release → single transfer.
- mem_busy pulsed during B1 of E8 02 04 → op1 still 0x02, op2 0x04, total latency +1 per busy cycle.
- RESET_PC=16'hFFFF, bytes FFFF=0xBA, 0000=0x07 → op1=0x07, next out_pc=0x0001.
- FF delivered → halted=1 after transfer, out_valid stays 0, redirect ignored; rst_n low mid-B1 → immediate reset values.
